// File: rtl/dll_rx_checker.sv
// dll_rx_checker: receive-side data-link checker.
// Checks CRC-16 and sequence number of each 128-bit frame, forwards good
// in-order payloads, and returns ACK/NAK DLLPs over a valid/ready handshake.
// Optional feature macro: ACK_COALESCE_EN (adds WAIT state + coalescing timer).
module dll_rx_checker #(
    parameter int SEQ_W       = 12,
    parameter int ACK_LATENCY = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tlp_in_valid,
    input  logic [127:0]     tlp_in,
    output logic             tlp_out_valid,
    output logic [99:0]      tlp_out,
    output logic             dllp_valid,
    input  logic             dllp_ready,
    output logic             dllp_nak,
    output logic [SEQ_W-1:0] dllp_seq,
    output logic [SEQ_W-1:0] next_rcv_seq
);

    // Distances 1..HALF_RANGE behind NRS count as duplicates.
    localparam logic [SEQ_W-1:0] HALF_RANGE = SEQ_W'(1) << (SEQ_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ACK_COALESCE_EN
        S_WAIT = 2'd1,
`endif
        S_SEND = 2'd2
    } state_t;

    // CRC-16-CCITT, init 0xFFFF, MSB first, no reflection, no final XOR.
    function automatic logic [15:0] crc16(input logic [111:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 111; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [SEQ_W-1:0] r_nrs;
    logic             r_nak_sched;
    logic             r_nak_pending;
    logic             r_ack_pending;
    logic             r_tlp_out_valid;
    logic [99:0]      r_tlp_out;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_dllp_nak;
    logic [SEQ_W-1:0] r_dllp_seq;
    logic             w_load;
    logic             w_load_nak;
    logic             w_eval_idle;
    logic [SEQ_W-1:0] w_seq;
    logic [SEQ_W-1:0] w_dist;
    logic             w_crc_ok;
    logic             w_in_order;
    logic             w_dup;
    logic             w_lost;
    logic             w_ack_set;
    logic             w_nak_set;
`ifdef ACK_COALESCE_EN
    logic [7:0]       r_timer;
`else
    // ACK_LATENCY has no effect without coalescing.
    logic             w_unused_cfg;
    assign w_unused_cfg = (ACK_LATENCY > 0);
`endif

    // Classification of the incoming word.
    assign w_seq      = tlp_in[127 -: SEQ_W];
    assign w_dist     = r_nrs - w_seq;
    assign w_crc_ok   = (crc16(tlp_in[127:16]) == tlp_in[15:0]);
    assign w_in_order = tlp_in_valid && w_crc_ok && (w_seq == r_nrs);
    assign w_dup      = tlp_in_valid && w_crc_ok && (w_dist != '0) && (w_dist <= HALF_RANGE);
    assign w_lost     = tlp_in_valid && !w_in_order && !w_dup;
    assign w_ack_set  = w_in_order || w_dup;
    assign w_nak_set  = w_lost && !r_nak_sched;

    // Receive datapath: NRS, NAK-scheduled flag and forwarded payload.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nrs           <= '0;
            r_nak_sched     <= 1'b0;
            r_tlp_out_valid <= 1'b0;
            r_tlp_out       <= '0;
        end else begin
            r_tlp_out_valid <= w_in_order;
            if (w_in_order) begin
                r_tlp_out   <= tlp_in[115:16];
                r_nrs       <= r_nrs + 1'b1;
                r_nak_sched <= 1'b0;
            end else if (w_lost) begin
                r_nak_sched <= 1'b1;
            end
        end
    end

    // DLLP next-state logic; SEND with a handshake re-evaluates exactly like IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_nak  = 1'b0;
        w_eval_idle = 1'b0;
        case (r_state)
            S_IDLE: w_eval_idle = 1'b1;
`ifdef ACK_COALESCE_EN
            S_WAIT: begin
                if (r_nak_pending) begin
                    w_state_nxt = S_SEND;
                    w_load      = 1'b1;
                    w_load_nak  = 1'b1;
                end else if (r_timer == 8'(ACK_LATENCY - 1)) begin
                    w_state_nxt = S_SEND;
                    w_load      = 1'b1;
                end
            end
`endif
            S_SEND: w_eval_idle = dllp_ready;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_eval_idle) begin
            w_state_nxt = S_IDLE;
            if (r_nak_pending) begin
                w_state_nxt = S_SEND;
                w_load      = 1'b1;
                w_load_nak  = 1'b1;
            end else if (r_ack_pending) begin
`ifdef ACK_COALESCE_EN
                w_state_nxt = S_WAIT;
`else
                w_state_nxt = S_SEND;
                w_load      = 1'b1;
`endif
            end
        end
    end

    // Pending flags: consumed when a DLLP is loaded, so events arriving while
    // it is offered produce a follow-up DLLP. A set always beats a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_nak_pending <= 1'b0;
            r_ack_pending <= 1'b0;
        end else begin
            if (w_nak_set)                r_nak_pending <= 1'b1;
            else if (w_load && w_load_nak) r_nak_pending <= 1'b0;
            if (w_ack_set)                r_ack_pending <= 1'b1;
            else if (w_load)              r_ack_pending <= 1'b0;
        end
    end

    // State register and DLLP contents, frozen from SEND entry to handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_dllp_nak <= 1'b0;
            r_dllp_seq <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_dllp_nak <= w_load_nak;
                r_dllp_seq <= r_nrs - 1'b1;
            end
        end
    end

`ifdef ACK_COALESCE_EN
    // Coalescing timer: cleared on WAIT entry, counts every cycle in WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (w_state_nxt == S_WAIT && r_state != S_WAIT) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT) begin
            r_timer <= r_timer + 8'd1;
        end
    end
`endif

    assign tlp_out_valid = r_tlp_out_valid;
    assign tlp_out       = r_tlp_out;
    assign dllp_valid    = (r_state == S_SEND);
    assign dllp_nak      = r_dllp_nak;
    assign dllp_seq      = r_dllp_seq;
    assign next_rcv_seq  = r_nrs;

endmodule

// File: tb/tb_dll_rx_checker.sv
// tb_dll_rx_checker: directed and randomized bench for dll_rx_checker.
// Follows ACK_COALESCE_EN for the expected ACK timing.
module tb_dll_rx_checker;

    localparam int L = 8;
`ifdef ACK_COALESCE_EN
    localparam int ACKD = 2 + L;
`else
    localparam int ACKD = 2;
`endif

    logic         clk;
    logic         rst;
    logic         tlp_in_valid;
    logic [127:0] tlp_in;
    logic         tlp_out_valid;
    logic [99:0]  tlp_out;
    logic         dllp_valid;
    logic         dllp_ready;
    logic         dllp_nak;
    logic [11:0]  dllp_seq;
    logic [11:0]  next_rcv_seq;

    dll_rx_checker #(.SEQ_W(12), .ACK_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .tlp_in_valid(tlp_in_valid), .tlp_in(tlp_in),
        .tlp_out_valid(tlp_out_valid), .tlp_out(tlp_out),
        .dllp_valid(dllp_valid), .dllp_ready(dllp_ready),
        .dllp_nak(dllp_nak), .dllp_seq(dllp_seq),
        .next_rcv_seq(next_rcv_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit nak; logic [11:0] seq; } dl_t;
    typedef struct { int cyc; logic [99:0] pl; } out_t;
    dl_t  off_q[$];
    dl_t  hs_q[$];
    out_t got_q[$];
    out_t exp_q[$];
    int   stab_err = 0;
    bit   pv = 0, phs = 0, pnak = 0;
    logic [11:0] pseq = '0;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [11:0] m_nrs = '0;

    // Observe outputs on the falling edge.
    always @(negedge clk) begin
        dl_t  d;
        out_t o;
        d.cyc = cyc; d.nak = dllp_nak; d.seq = dllp_seq;
        if (tlp_out_valid === 1'b1) begin
            o.cyc = cyc; o.pl = tlp_out;
            got_q.push_back(o);
        end
        if (dllp_valid === 1'b1 && (!pv || phs)) off_q.push_back(d);
        if (pv && !phs && dllp_valid === 1'b1 && (dllp_nak !== pnak || dllp_seq !== pseq))
            stab_err++;
        if (dllp_valid === 1'b1 && dllp_ready === 1'b1) hs_q.push_back(d);
        pv   = (dllp_valid === 1'b1);
        phs  = (dllp_valid === 1'b1) && (dllp_ready === 1'b1);
        pnak = (dllp_nak === 1'b1);
        pseq = dllp_seq;
    end

    // Reference CRC: polynomial division of the 112 frame bits, MSB first.
    function automatic logic [15:0] crc_ref(input logic [111:0] d);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 111; i >= 0; i--) begin
            logic top;
            top = r[15] ^ d[i];
            r   = r << 1;
            if (top) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    function automatic logic [127:0] make_word(input logic [11:0] seq, input logic [99:0] pl, input bit bad);
        logic [127:0] w;
        w = {seq, pl, 16'h0000};
        w[15:0] = crc_ref(w[127:16]) ^ {15'd0, bad};
        return w;
    endfunction

    function automatic logic [99:0] rnd_pl();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[99:0];
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive one word for one cycle and advance the reference model.
    task automatic send(input logic [11:0] seq, input logic [99:0] pl, input bit bad, output int c);
        out_t e;
        tlp_in       = make_word(seq, pl, bad);
        tlp_in_valid = 1'b1;
        c            = cyc;
        if (!bad && seq == m_nrs) begin
            e.cyc = cyc + 1; e.pl = pl;
            exp_q.push_back(e);
            m_nrs = m_nrs + 12'd1;
        end
        @(posedge clk); #1;
        tlp_in_valid = 1'b0;
    endtask

    task automatic clear_q();
        got_q.delete(); exp_q.delete(); off_q.delete(); hs_q.delete();
        stab_err = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0; tlp_in_valid = 1'b0; tlp_in = '0; dllp_ready = 1'b1;
        idle(2);
        rst = 1'b1;
        m_nrs = '0;
        idle(1);
        clear_q();
    endtask

    task automatic check_outs(input string tag);
        check({tag, "_cnt"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_cyc%0d", tag, i), got_q[i].cyc, exp_q[i].cyc);
            check($sformatf("%s_pl%0d", tag, i), got_q[i].pl, exp_q[i].pl);
        end
    endtask

    // Check one recorded DLLP (offer or handshake); ecyc < 0 skips timing.
    task automatic check_ent(input string tag, input bit hs, input int idx, input int ecyc,
                             input bit enak, input logic [11:0] eseq);
        dl_t e;
        int  n;
        n = hs ? hs_q.size() : off_q.size();
        if (idx >= 0 && idx < n) begin
            e = hs ? hs_q[idx] : off_q[idx];
            if (ecyc >= 0) check({tag, "_cyc"}, e.cyc, ecyc);
            check({tag, "_nak"}, e.nak, enak);
            check({tag, "_seq"}, e.seq, eseq);
        end else begin
            check({tag, "_present"}, n, idx + 1);
        end
    endtask

    initial begin
        int c0, c, cnt;
        logic [11:0] s;
        int r;

        // Reset state
        do_reset();
        check("rst_tlp_out_valid", tlp_out_valid, 1'b0);
        check("rst_tlp_out", tlp_out, 100'd0);
        check("rst_dllp_valid", dllp_valid, 1'b0);
        check("rst_dllp_nak", dllp_nak, 1'b0);
        check("rst_dllp_seq", dllp_seq, 12'd0);
        check("rst_nrs", next_rcv_seq, 12'd0);

        // Three good TLPs back to back
        send(12'd0, rnd_pl(), 1'b0, c0);
        send(12'd1, rnd_pl(), 1'b0, c);
        send(12'd2, rnd_pl(), 1'b0, c);
        idle(20);
        check_outs("t1_out");
        check("t1_nrs", next_rcv_seq, 12'd3);
`ifdef ACK_COALESCE_EN
        check("t1_nack", off_q.size(), 1);
        check_ent("t1_ack", 1'b0, 0, c0 + 2 + L, 1'b0, 12'd2);
`else
        check("t1_nack", off_q.size(), 3);
        check_ent("t1_ack0", 1'b0, 0, c0 + 2, 1'b0, 12'd0);
        check_ent("t1_ack1", 1'b0, 1, c0 + 3, 1'b0, 12'd1);
        check_ent("t1_ack2", 1'b0, 2, c0 + 4, 1'b0, 12'd2);
`endif

        // Bad CRC twice: a single NAK for seq 0
        do_reset();
        send(12'd0, rnd_pl(), 1'b0, c0);
        send(12'd1, rnd_pl(), 1'b1, c);
        send(12'd1, rnd_pl(), 1'b1, c);
        idle(20);
        cnt = 0;
        foreach (off_q[i]) begin
            if (off_q[i].nak) begin
                cnt++;
                check("t2_nak_cyc", off_q[i].cyc, c0 + 3);
            end
            check($sformatf("t2_seq%0d", i), off_q[i].seq, 12'd0);
        end
        check("t2_nak_count", cnt, 1);
        check("t2_nrs", next_rcv_seq, 12'd1);
        clear_q();
        send(12'd1, rnd_pl(), 1'b0, c);
        idle(20);
        check_outs("t2_out");
        check("t2_nack", off_q.size(), 1);
        check_ent("t2_ack", 1'b0, 0, c + ACKD, 1'b0, 12'd1);
        clear_q();
        send(12'd2, rnd_pl(), 1'b1, c);
        idle(6);
        check_ent("t2_renak", 1'b0, 0, c + 2, 1'b1, 12'd1);

        // Duplicate and future sequence numbers at NRS=5
        do_reset();
        for (int i = 0; i < 5; i++) send(12'(i), rnd_pl(), 1'b0, c);
        idle(20);
        clear_q();
        send(12'd3, rnd_pl(), 1'b0, c);
        idle(20);
        check_outs("t3_dup_out");
        check("t3_dup_nack", off_q.size(), 1);
        check_ent("t3_dup_ack", 1'b0, 0, c + ACKD, 1'b0, 12'd4);
        clear_q();
        send(12'd9, rnd_pl(), 1'b0, c);
        idle(6);
        check_outs("t3_fut_out");
        check_ent("t3_fut_nak", 1'b0, 0, c + 2, 1'b1, 12'd4);
        check("t3_nrs", next_rcv_seq, 12'd5);

        // Sequence wrap
        do_reset();
        for (int i = 0; i < 4095; i++) send(12'(i), rnd_pl(), 1'b0, c);
        idle(20);
        check_outs("t4_fill");
        check("t4_nrs_4095", next_rcv_seq, 12'd4095);
        clear_q();
        send(12'd4095, rnd_pl(), 1'b0, c);
        idle(20);
        check_outs("t4_wrap_out");
        check("t4_nrs_0", next_rcv_seq, 12'd0);
        check_ent("t4_ack", 1'b0, off_q.size() - 1, c + ACKD, 1'b0, 12'd4095);
        clear_q();
        send(12'd0, rnd_pl(), 1'b0, c);
        idle(3);
        check_outs("t4_seq0_out");
        check("t4_nrs_1", next_rcv_seq, 12'd1);

        // NAK held 20+ cycles while good TLPs keep arriving
        do_reset();
        for (int i = 0; i < 3; i++) send(12'(i), rnd_pl(), 1'b0, c);
        idle(20);
        clear_q();
        dllp_ready = 1'b0;
        send(12'd3, rnd_pl(), 1'b1, c0);
        for (int i = 3; i < 13; i++) send(12'(i), rnd_pl(), 1'b0, c);
        idle(10);
        check("t5_noffer", off_q.size(), 1);
        check_ent("t5_nak_off", 1'b0, 0, c0 + 2, 1'b1, 12'd2);
        check("t5_stable", stab_err, 0);
        check("t5_still_valid", dllp_valid, 1'b1);
        check("t5_held_nak", dllp_nak, 1'b1);
        check("t5_held_seq", dllp_seq, 12'd2);
        dllp_ready = 1'b1;
        idle(20);
        check("t5_nhs", hs_q.size(), 2);
        check_ent("t5_hs_nak", 1'b1, 0, -1, 1'b1, 12'd2);
        check_ent("t5_hs_ack", 1'b1, 1, -1, 1'b0, 12'd12);
        check_outs("t5_out");
        check("t5_nrs", next_rcv_seq, 12'd13);

        // Asynchronous reset while a DLLP is offered
        do_reset();
        for (int i = 0; i < 4; i++) send(12'(i), rnd_pl(), 1'b0, c);
        idle(20);
        dllp_ready = 1'b0;
        send(12'd4, rnd_pl(), 1'b1, c);
        idle(3);
        check("t6_offered", dllp_valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_valid", dllp_valid, 1'b0);
        check("t6_rst_nrs", next_rcv_seq, 12'd0);
        check("t6_rst_out_valid", tlp_out_valid, 1'b0);
        idle(2);
        rst = 1'b1;
        dllp_ready = 1'b1;
        m_nrs = '0;
        idle(1);
        clear_q();
        send(12'd0, rnd_pl(), 1'b0, c);
        idle(20);
        check_outs("t6_out");
        check("t6_nrs", next_rcv_seq, 12'd1);
        check_ent("t6_ack", 1'b0, 0, c + ACKD, 1'b0, 12'd0);

        // Randomized traffic with random DLLP backpressure
        do_reset();
        for (int i = 0; i < 600; i++) begin
            dllp_ready = ($urandom_range(0, 3) != 0);
            r = int'($urandom_range(0, 9));
            if (r < 2) begin
                idle(1);
            end else begin
                case (r)
                    2, 3:    s = m_nrs - 12'($urandom_range(1, 2048));
                    4:       s = m_nrs + 12'($urandom_range(1, 2047));
                    default: s = m_nrs;
                endcase
                send(s, rnd_pl(), ($urandom_range(0, 5) == 0), c);
            end
        end
        dllp_ready = 1'b1;
        idle(40);
        check_outs("rnd_out");
        check("rnd_nrs", next_rcv_seq, m_nrs);
        check("rnd_stable", stab_err, 0);
        if (hs_q.size() > 0) check("rnd_last_seq", hs_q[hs_q.size() - 1].seq, m_nrs - 12'd1);
        else                 check("rnd_any_dllp", hs_q.size(), 1);
        check("rnd_idle", dllp_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
